// File: rtl/latch128_arb.sv
// rtl/latch128_arb.sv - round-robin arbiter feeding a one-entry 128-bit holding register
// Grants one eligible requester per cycle and presents its word downstream with back-pressure.
module latch128_arb #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 128,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear_i,
   input  logic [NUM_REQ-1:0]       req_mask_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   output logic [WIDTH-1:0]         out_data_o,
   output logic [IDX_W-1:0]         out_src_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic                     busy_o
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant;
   logic [IDX_W-1:0]   grant_next;
   logic [NUM_REQ-1:0] eligible;
   logic               any_eligible;
   logic               can_accept;
   logic               accept;

   assign eligible     = req_valid_i & req_mask_i;
   assign any_eligible = |eligible;

   // Scan farthest-first so the eligible index closest to rr_ptr is the last writer.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] cand;
      grant = '0;
      idx   = 0;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = IDX_W'(idx);
         if (eligible[cand]) grant = cand;
      end
   end

   assign grant_next  = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
   assign can_accept  = resetn & ~clear_i & ((state_q == EMPTY) | out_ready_i);
   assign accept      = can_accept & any_eligible;
   assign req_ready_o = accept ? (NUM_REQ'(1) << grant) : '0;
   assign out_valid_o = (state_q == FULL);
   assign busy_o      = out_valid_o | any_eligible;

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d = FULL;
      end else if ((state_q == FULL) && out_ready_i) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= EMPTY;
         rr_ptr     <= '0;
         out_data_o <= '0;
         out_src_o  <= '0;
      end else begin
         state_q <= state_d;
         if (clear_i) begin
            out_data_o <= '0;
            out_src_o  <= '0;
         end else if (accept) begin
            out_data_o <= req_data_i[int'(grant)*WIDTH +: WIDTH];
            out_src_o  <= grant;
            rr_ptr     <= grant_next;
         end
      end
   end

endmodule

// File: tb/tb_latch128_arb.sv
// tb/tb_latch128_arb.sv - scoreboard bench for latch128_arb
// Stimulus pushes expected {src,data} on each grant; a negedge monitor pops on every output handshake.
module tb_latch128_arb;
   localparam int N  = 4;
   localparam int W  = 128;
   localparam int IW = 2;

   localparam logic [W-1:0] D0 = {16{8'h3C}};
   localparam logic [W-1:0] D1 = {4{32'hDEADBEEF}};
   localparam logic [W-1:0] D2 = {16{8'hA5}};
   localparam logic [W-1:0] D3 = {2{64'h0F1E2D3C4B5A6978}};

   typedef struct packed {
      logic [IW-1:0] src;
      logic [W-1:0]  data;
   } item_t;

   logic           clk = 1'b0;
   logic           resetn;
   logic           clear_i;
   logic [N-1:0]   req_mask_i;
   logic [N-1:0]   req_valid_i;
   logic [N*W-1:0] req_data_i;
   logic [N-1:0]   req_ready_o;
   logic [W-1:0]   out_data_o;
   logic [IW-1:0]  out_src_o;
   logic           out_valid_o;
   logic           out_ready_i;
   logic           busy_o;

   item_t sb[$];
   item_t mon_item;
   int    n_cmp = 0;
   int    n_bad = 0;

   latch128_arb #(.NUM_REQ(N), .WIDTH(W), .IDX_W(IW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .clear_i     (clear_i),
      .req_mask_i  (req_mask_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .out_data_o  (out_data_o),
      .out_src_o   (out_src_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] dsel(input int i);
      case (i)
         0:       return D0;
         1:       return D1;
         2:       return D2;
         default: return D3;
      endcase
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input int g, input string name);
      sb.push_back({IW'(g), dsel(g)});
      @(negedge clk);
      check(name, W'(req_ready_o), W'(4'b0001 << g));
   endtask

   task automatic do_reset();
      cyc();
      resetn      = 1'b0;
      req_valid_i = '0;
      out_ready_i = 1'b0;
      clear_i     = 1'b0;
      req_mask_i  = '1;
      cyc();
      resetn = 1'b1;
   endtask

   always @(negedge clk) begin
      if (resetn && !clear_i && out_valid_o && out_ready_i) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got src %0d, expected no word", out_src_o);
         end else begin
            mon_item = sb.pop_front();
            check("sb_src", W'(out_src_o), W'(mon_item.src));
            check("sb_data", out_data_o, mon_item.data);
         end
      end
   end

   initial begin
      resetn      = 1'b0;
      clear_i     = 1'b0;
      req_mask_i  = '1;
      req_valid_i = 4'b0100;
      out_ready_i = 1'b0;
      req_data_i  = {D3, D2, D1, D0};

      cyc();
      cyc();
      @(negedge clk);
      check("rst_valid", W'(out_valid_o), W'(0));
      check("rst_src", W'(out_src_o), W'(0));
      check("rst_data", out_data_o, '0);
      check("rst_ready", W'(req_ready_o), W'(0));

      // single request
      cyc();
      resetn = 1'b1;
      expect_grant(2, "t1_grant");
      cyc();
      @(negedge clk);
      check("t1_valid", W'(out_valid_o), W'(1));
      check("t1_src", W'(out_src_o), W'(2));
      check("t1_data", out_data_o, D2);
      check("t1_ready_full", W'(req_ready_o), W'(0));
      cyc();
      @(negedge clk);
      check("t1_ready_hold", W'(req_ready_o), W'(0));
      cyc();
      out_ready_i = 1'b1;
      expect_grant(2, "t1_refill");
      cyc();
      req_valid_i = '0;
      @(negedge clk);
      cyc();
      @(negedge clk);
      check("t1_empty", W'(out_valid_o), W'(0));
      check("t1_busy", W'(busy_o), W'(0));

      // round-robin at full throughput
      do_reset();
      req_valid_i = 4'b1111;
      out_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         expect_grant(k % 4, "rr_grant");
         if (k > 0) check("rr_no_bubble", W'(out_valid_o), W'(1));
         cyc();
      end
      req_valid_i = '0;
      @(negedge clk);
      cyc();
      @(negedge clk);
      check("rr_empty", W'(out_valid_o), W'(0));

      // back-pressure
      cyc();
      req_valid_i = 4'b0001;
      out_ready_i = 1'b0;
      expect_grant(0, "bp_load");
      cyc();
      req_valid_i = 4'b1010;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_ready", W'(req_ready_o), W'(0));
         check("bp_src", W'(out_src_o), W'(0));
         check("bp_data", out_data_o, D0);
         cyc();
      end
      out_ready_i = 1'b1;
      expect_grant(1, "bp_refill1");
      cyc();
      expect_grant(3, "bp_refill3");
      cyc();
      req_valid_i = '0;
      @(negedge clk);
      cyc();
      @(negedge clk);
      check("bp_empty", W'(out_valid_o), W'(0));

      // mask requester 1
      cyc();
      req_mask_i  = 4'b1101;
      req_valid_i = 4'b1111;
      out_ready_i = 1'b1;
      expect_grant(0, "mask_g0");
      cyc();
      expect_grant(2, "mask_g2");
      cyc();
      expect_grant(3, "mask_g3");
      cyc();
      expect_grant(0, "mask_g0b");
      cyc();
      req_valid_i = '0;
      @(negedge clk);
      cyc();
      req_valid_i = 4'b0010;
      @(negedge clk);
      check("mask_ready", W'(req_ready_o), W'(0));
      check("mask_busy", W'(busy_o), W'(0));

      // clear collision; rr_ptr is 1 here
      cyc();
      req_mask_i  = '1;
      req_valid_i = 4'b0100;
      out_ready_i = 1'b0;
      @(negedge clk);
      check("cl_load_ready", W'(req_ready_o), W'(4'b0100));
      cyc();
      req_valid_i = 4'b0001;
      clear_i     = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk);
      check("cl_full_src", W'(out_src_o), W'(2));
      check("cl_ready", W'(req_ready_o), W'(0));
      cyc();
      clear_i     = 1'b0;
      req_valid_i = 4'b1111;
      out_ready_i = 1'b0;
      @(negedge clk);
      check("cl_valid", W'(out_valid_o), W'(0));
      check("cl_data", out_data_o, '0);
      check("cl_src", W'(out_src_o), W'(0));
      check("cl_ptr_kept", W'(req_ready_o), W'(4'b1000));
      cyc();
      @(negedge clk);
      check("mr_pre_valid", W'(out_valid_o), W'(1));
      check("mr_pre_src", W'(out_src_o), W'(3));

      // mid-operation reset
      cyc();
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      @(negedge clk);
      check("mr_valid", W'(out_valid_o), W'(0));
      check("mr_src", W'(out_src_o), W'(0));
      sb.push_back({IW'(0), D0});
      check("mr_grant", W'(req_ready_o), W'(4'b0001));
      cyc();
      req_valid_i = '0;
      out_ready_i = 1'b1;
      @(negedge clk);
      cyc();
      @(negedge clk);
      check("sb_drained", W'(sb.size()), W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
